// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, state encoding and cost type
// for the job-assignment cost loader.
package jam_pkg;

  localparam int COST_W = 7;
  localparam int N      = 8;
  localparam int SUM_W  = 10;
  localparam int IDX_W  = 6;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } state_e;

  typedef logic [COST_W-1:0] cost_t;

endpackage

// File: rtl/jam_row_min.sv
// jam_row_min: running row minimum and row-minimum sum.
// Ports: clk, rst_n, clr, en, col, word in; sum out.
module jam_row_min
  import jam_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       col,
  input  cost_t            word,
  output logic [SUM_W-1:0] sum
);

  cost_t            rmin_q, rmin_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  cost_t            m;

  assign m   = (word < rmin_q) ? word : rmin_q;
  assign sum = sum_q;

  always_comb begin
    rmin_d = rmin_q;
    sum_d  = sum_q;
    if (clr) begin
      rmin_d = '0;
      sum_d  = '0;
    end else if (en) begin
      unique case (1'b1)
        (col == 3'd0): rmin_d = word;
        (col == 3'd7): begin
          rmin_d = m;
          sum_d  = sum_q + SUM_W'(m);
        end
        default: rmin_d = m;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmin_q <= '0;
      sum_q  <= '0;
    end else begin
      rmin_q <= rmin_d;
      sum_q  <= sum_d;
    end
  end

endmodule

// File: rtl/jam_cost_loader.sv
// jam_cost_loader: streams an 8x8 cost matrix into a regfile,
// serves Cost[W][J], lower_bound, load_done/err, solve_start.
module jam_cost_loader
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  cost_t            in_data,
  input  logic             in_last,
  input  logic [2:0]       W,
  input  logic [2:0]       J,
  output cost_t            Cost,
  output logic             load_done,
  output logic             load_err,
  output logic [SUM_W-1:0] lower_bound,
  output logic             solve_start
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_q, start_d;
  cost_t            mat_q [N][N];
  cost_t            mat_d [N][N];
  logic             xfer;
  logic             at_end;

  assign in_ready    = (state_q == LOAD);
  assign xfer        = in_valid & in_ready & ~clear;
  assign at_end      = (idx_q == 6'd63);
  assign load_done   = (state_q == DONE);
  assign load_err    = (state_q == ERR);
  assign solve_start = start_q;
  assign Cost        = mat_q[W][J];

  always_comb begin
    mat_d = mat_q;
    if (xfer) begin
      mat_d[idx_q[5:3]][idx_q[2:0]] = in_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start_d = 1'b0;
    if (clear) begin
      state_d = LOAD;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (xfer) begin
            idx_d = idx_q + 6'd1;
            if (at_end && in_last) begin
              state_d = DONE;
              start_d = 1'b1;
            end else if (at_end || in_last) begin
              state_d = ERR;
            end
          end
        end
        DONE:    state_d = DONE;
        ERR:     state_d = ERR;
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= LOAD;
      idx_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else begin
      mat_q <= mat_d;
    end
  end

  jam_row_min u_row_min (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (clear),
    .en    (xfer),
    .col   (idx_q[2:0]),
    .word  (in_data),
    .sum   (lower_bound)
  );

endmodule

// File: tb/tb_jam_cost_loader.sv
// tb_jam_cost_loader: directed bench for jam_cost_loader.
// Drives on negedge, samples between edges.
module tb_jam_cost_loader;
  import jam_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  cost_t            in_data;
  logic             in_last;
  logic [2:0]       W;
  logic [2:0]       J;
  cost_t            Cost;
  logic             load_done;
  logic             load_err;
  logic [SUM_W-1:0] lower_bound;
  logic             solve_start;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  jam_cost_loader dut (
    .CLK         (CLK),
    .RST         (RST),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .W           (W),
    .J           (J),
    .Cost        (Cost),
    .load_done   (load_done),
    .load_err    (load_err),
    .lower_bound (lower_bound),
    .solve_start (solve_start)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  function automatic cost_t val(input int mode, input int k);
    case (mode)
      0:       return cost_t'(k % 100);
      1:       return cost_t'(127);
      default: return cost_t'(127 - k);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the last word.
  task automatic load(input int first, input int cnt,
                      input int mode, input int last_at,
                      input bit gaps);
    for (int k = first; k < first + cnt; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(negedge CLK);
        end
      end
      in_valid = 1'b1;
      in_data  = val(mode, k);
      in_last  = (k == last_at);
      if (gaps) check("rdy_gap", 32'(in_ready), 32'd1);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cost_at(input int w, input int j,
                         input int exp);
    W = 3'(w);
    J = 3'(j);
    #1;
    check($sformatf("cost_%0d_%0d", w, j),
          32'(Cost), 32'(exp));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
  endtask

  task automatic idle_outs(input string tag);
    check({tag, "_rdy"},  32'(in_ready),    32'd1);
    check({tag, "_done"}, 32'(load_done),   32'd0);
    check({tag, "_err"},  32'(load_err),    32'd0);
    check({tag, "_lb"},   32'(lower_bound), 32'd0);
    check({tag, "_ss"},   32'(solve_start), 32'd0);
  endtask

  initial begin
    RST      = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    W        = '0;
    J        = '0;
    repeat (2) @(negedge CLK);
    idle_outs("rst");
    cost_at(3, 5, 0);
    RST = 1'b1;
    @(negedge CLK);

    // 1: ramp matrix, continuous valid
    load(0, 63, 0, 63, 1'b0);
    check("t1_done_early", 32'(load_done), 32'd0);
    load(63, 1, 0, 63, 1'b0);
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_ss",   32'(solve_start), 32'd1);
    check("t1_rdy",  32'(in_ready), 32'd0);
    check("t1_lb",   32'(lower_bound), 32'd224);
    cost_at(3, 5, 29);
    cost_at(7, 7, 63);
    @(negedge CLK);
    check("t1_ss_off", 32'(solve_start), 32'd0);
    check("t1_done2",  32'(load_done), 32'd1);
    in_valid = 1'b1;
    in_data  = 7'd1;
    @(negedge CLK);
    in_valid = 1'b0;
    cost_at(0, 0, 0);
    check("t1_lb_hold", 32'(lower_bound), 32'd224);

    // 2: all 127 with random gaps
    do_clear();
    idle_outs("clr2");
    load(0, 64, 1, 63, 1'b1);
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_lb",   32'(lower_bound), 32'd1016);
    cost_at(0, 0, 127);
    cost_at(5, 2, 127);

    // 3: early in_last on word 40
    do_clear();
    load(0, 41, 0, 40, 1'b0);
    check("t3_err",  32'(load_err), 32'd1);
    check("t3_rdy",  32'(in_ready), 32'd0);
    check("t3_done", 32'(load_done), 32'd0);
    cost_at(5, 0, 40);
    do_clear();
    check("t3_err_clr", 32'(load_err), 32'd0);
    check("t3_rdy_clr", 32'(in_ready), 32'd1);
    load(0, 64, 0, 63, 1'b0);
    check("t3_done2", 32'(load_done), 32'd1);
    check("t3_lb",    32'(lower_bound), 32'd224);

    // 4: no in_last at word 63
    do_clear();
    load(0, 64, 0, -1, 1'b0);
    check("t4_err",  32'(load_err), 32'd1);
    check("t4_ss",   32'(solve_start), 32'd0);
    check("t4_done", 32'(load_done), 32'd0);
    @(negedge CLK);
    check("t4_ss2",  32'(solve_start), 32'd0);

    // 5: clear coincides with word 20
    do_clear();
    load(0, 20, 0, 63, 1'b0);
    in_valid = 1'b1;
    in_data  = 7'd5;
    clear    = 1'b1;
    @(negedge CLK);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5_lb_clr", 32'(lower_bound), 32'd0);
    cost_at(2, 4, 20);
    load(0, 64, 2, 63, 1'b0);
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_lb",   32'(lower_bound), 32'd736);
    cost_at(0, 0, 127);
    cost_at(2, 4, 107);

    // 6: reset mid-load
    do_clear();
    load(0, 30, 0, 63, 1'b0);
    in_valid = 1'b1;
    in_data  = 7'd30;
    #2;
    RST = 1'b0;
    #1;
    idle_outs("t6");
    @(negedge CLK);
    in_valid = 1'b0;
    RST = 1'b1;
    idle_outs("t6r");
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        cost_at(w, j, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
